bubble_host_reader: RTL and testbench

Host-side counterpart of the bubble emulator's output path. It drives the bubble control strobes (nBSEN, nREPEN, nBOOTEN) the way a Bubble System host board does and captures one page of serial data from DOUT0/DOUT1 into a capture RAM write port. It sits in the self-test/loopback build, wired back-to-back with the emulator top so a full page read can be checked on hardware and in simulation without the arcade board.

---
 rtl/bubble_host_pkg.sv | 28 ++
 rtl/bubble_sync2.sv | 29 ++
 rtl/bubble_host_reader.sv | 143 ++++++++++++++
 tb/tb_bubble_host_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bubble_host_pkg.sv
// bubble_host_pkg
// Shared definitions for the bubble host reader: FSM state encoding and the
// default bubble timing constants. The emulator-side timing generator uses
// the same constants, so both ends of the loopback agree on the bit timing.
package bubble_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENABLE,
        ST_REPLICATE,
        ST_WAIT,
        ST_CAPTURE,
        ST_RELEASE
    } state_t;

    localparam int DEF_CYC_PER_BIT = 960;    // 20 us per bit at 48 MHz
    localparam int DEF_SETTLE      = 4800;
    localparam int DEF_REP_WIDTH   = 48;
    localparam int DEF_LATENCY     = 19200;
    localparam int DEF_PAGE_BITS   = 512;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bubble_sync2.sv
// bubble_sync2
// Two-flop synchronizer for signals asynchronous to clk, reset to 0.
// Ports:
//   clk  in  sampling clock
//   rst  in  asynchronous active-high reset
//   d    in  [W-1:0] asynchronous input
//   q    out [W-1:0] synchronized output (two clk cycles of latency)
module bubble_sync2 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bubble_host_reader.sv
// bubble_host_reader
// Host-side bubble page reader: drives nBSEN / nREPEN / nBOOTEN like a
// Bubble System host board and captures one page of DOUT1/DOUT0 bits into a
// capture RAM write port.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for START, all strobes inactive
// ENABLE     | nBSEN low, settling for SETTLE cycles
// REPLICATE  | nREPEN low for REP_WIDTH cycles
// WAIT       | LATENCY cycles until bit 0 starts
// CAPTURE    | sample mid-bit, one write strobe per bit
// RELEASE    | single cycle: strobes released, DONE pulsed
//
// Ports:
//   MCLK, RESET           clock, asynchronous active-high reset
//   START, ABORT          access request / cancel
//   BOOTMODE              latched at START; selects nBOOTEN during the access
//   BUSY, DONE            access in progress / one-cycle completion pulse
//   nBSEN, nREPEN, nBOOTEN  bubble control strobes, active low
//   DOUT0, DOUT1          bubble data lines, asynchronous
//   nCAPWCLKEN, CAPWADDR, CAPWDATA  capture RAM write port
module bubble_host_reader
    import bubble_host_pkg::*;
#(
    parameter int CYC_PER_BIT = DEF_CYC_PER_BIT,
    parameter int SETTLE      = DEF_SETTLE,
    parameter int REP_WIDTH   = DEF_REP_WIDTH,
    parameter int LATENCY     = DEF_LATENCY,
    parameter int PAGE_BITS   = DEF_PAGE_BITS
) (
    input  logic                         MCLK,
    input  logic                         RESET,
    input  logic                         START,
    input  logic                         ABORT,
    input  logic                         BOOTMODE,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         nBSEN,
    output logic                         nREPEN,
    output logic                         nBOOTEN,
    input  logic                         DOUT0,
    input  logic                         DOUT1,
    output logic                         nCAPWCLKEN,
    output logic [$clog2(PAGE_BITS)-1:0] CAPWADDR,
    output logic [1:0]                   CAPWDATA
);

    localparam int TMR_W = $clog2(max3(SETTLE, LATENCY, REP_WIDTH) + 1);
    localparam int PH_W  = $clog2(CYC_PER_BIT);
    localparam int AW    = $clog2(PAGE_BITS);
    localparam int BW    = AW + 1;
    localparam int HALF  = CYC_PER_BIT / 2;

    state_t            state, nxt;
    logic [TMR_W-1:0]  tmr;
    logic [PH_W-1:0]   phase;
    logic [BW-1:0]     bit_cnt;
    logic              boot_q;
    logic              strobe;
    logic [1:0]        dout_s;
    logic              active;
    logic              sample;

    bubble_sync2 #(.W(2)) u_sync (
        .clk (MCLK),
        .rst (RESET),
        .d   ({DOUT1, DOUT0}),
        .q   (dout_s)
    );

    assign sample = (state == ST_CAPTURE) && (phase == PH_W'(HALF - 1));

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:      if (START)     nxt = ST_ENABLE;
            ST_ENABLE:    if (tmr == '0) nxt = ST_REPLICATE;
            ST_REPLICATE: if (tmr == '0) nxt = ST_WAIT;
            ST_WAIT:      if (tmr == '0) nxt = ST_CAPTURE;
            ST_CAPTURE:   if (strobe && bit_cnt == BW'(PAGE_BITS - 1)) nxt = ST_RELEASE;
            ST_RELEASE:   nxt = ST_IDLE;
            default:      nxt = ST_IDLE;
        endcase
        // Abort wins over every transition except from IDLE, where it is ignored.
        if (ABORT && state != ST_IDLE) nxt = ST_IDLE;
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            tmr      <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
            boot_q   <= 1'b0;
            strobe   <= 1'b0;
            CAPWADDR <= '0;
            CAPWDATA <= '0;
        end else begin
            // Strobe is registered one cycle after the sample so address and
            // data are already stable for the whole low cycle.
            strobe <= sample && !ABORT;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        boot_q <= BOOTMODE;
                        tmr    <= TMR_W'(SETTLE - 1);
                    end
                end
                ST_ENABLE:    tmr <= (tmr == '0) ? TMR_W'(REP_WIDTH - 1) : tmr - 1'b1;
                ST_REPLICATE: tmr <= (tmr == '0) ? TMR_W'(LATENCY - 1) : tmr - 1'b1;
                ST_WAIT: begin
                    if (tmr != '0) tmr <= tmr - 1'b1;
                    phase   <= '0;
                    bit_cnt <= '0;
                end
                ST_CAPTURE: begin
                    phase <= (phase == PH_W'(CYC_PER_BIT - 1)) ? '0 : phase + 1'b1;
                    if (sample) begin
                        CAPWADDR <= bit_cnt[AW-1:0];
                        CAPWDATA <= dout_s;
                    end
                    if (strobe) bit_cnt <= bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign active     = (state == ST_ENABLE) || (state == ST_REPLICATE) ||
                        (state == ST_WAIT)   || (state == ST_CAPTURE);
    assign BUSY       = active;
    assign DONE       = (state == ST_RELEASE);
    assign nBSEN      = !active;
    assign nREPEN     = !(state == ST_REPLICATE);
    assign nBOOTEN    = !(active && boot_q);
    assign nCAPWCLKEN = !strobe;

endmodule

// File: tb/tb_bubble_host_reader.sv
// Bench for bubble_host_reader with short timing parameters.
// Cycle numbering: cycle c is the clock period that ends at rising edge c;
// inputs are driven and outputs sampled on the falling edge inside it.
module tb_bubble_host_reader;

    localparam int CPB = 8;
    localparam int ST  = 10;
    localparam int RW  = 3;
    localparam int LAT = 20;
    localparam int PB  = 16;

    logic       MCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       BOOTMODE = 1'b0;
    logic       DOUT0 = 1'b0;
    logic       DOUT1 = 1'b0;
    logic       BUSY, DONE, nBSEN, nREPEN, nBOOTEN, nCAPWCLKEN;
    logic [3:0] CAPWADDR;
    logic [1:0] CAPWDATA;

    bubble_host_reader #(
        .CYC_PER_BIT (CPB),
        .SETTLE      (ST),
        .REP_WIDTH   (RW),
        .LATENCY     (LAT),
        .PAGE_BITS   (PB)
    ) dut (
        .MCLK       (MCLK),
        .RESET      (RESET),
        .START      (START),
        .ABORT      (ABORT),
        .BOOTMODE   (BOOTMODE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .nBSEN      (nBSEN),
        .nREPEN     (nREPEN),
        .nBOOTEN    (nBOOTEN),
        .DOUT0      (DOUT0),
        .DOUT1      (DOUT1),
        .nCAPWCLKEN (nCAPWCLKEN),
        .CAPWADDR   (CAPWADDR),
        .CAPWDATA   (CAPWDATA)
    );

    always #5 MCLK = ~MCLK;

    int ecount = 0;
    int base = 0;
    always @(posedge MCLK) ecount++;

    function automatic int cyc();
        return ecount - base;
    endfunction

    typedef struct {
        int c;
        int addr;
        int data;
    } ev_t;

    ev_t sq[$];
    int  dq[$];
    int  n_checks = 0;
    int  n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc(), act, exp);
        end
    endtask

    task automatic at_cycle(input int c);
        do @(negedge MCLK); while (cyc() < c);
    endtask

    // Expected strobes of an access started in cycle t0, keeping those that
    // fall before cycle 'limit'; optionally the DONE pulse.
    task automatic push_access(input int t0, input int limit, input bit with_done);
        ev_t e;
        for (int n = 0; n < PB; n++) begin
            e.c    = t0 + 1 + ST + RW + LAT + CPB / 2 + n * CPB;
            e.addr = n;
            e.data = n % 4;
            if (e.c < limit) sq.push_back(e);
        end
        if (with_done) dq.push_back(t0 + 2 + ST + RW + LAT + (PB - 1) * CPB + CPB / 2);
    endtask

    // DOUT pattern: bit N holds {N[1],N[0]} from dbase+N*CPB; optional
    // opposite-level glitch one cycle before the strobe of glitch_bit.
    int dbase = 134;
    int glitch_bit = -1;
    always @(negedge MCLK) begin
        int c, n;
        logic [1:0] v;
        c = cyc();
        n = (c >= dbase) ? (c - dbase) / CPB : 0;
        v = n[1:0];
        if (glitch_bit >= 0 && c == dbase + CPB / 2 - 1 + CPB * glitch_bit) v = ~v;
        {DOUT1, DOUT0} = v;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or DONE.
    always @(negedge MCLK) begin
        ev_t e;
        int  dc;
        if (nCAPWCLKEN === 1'b0) begin
            if (sq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected strobe at cycle %0d addr %0d data %0d", cyc(), CAPWADDR, CAPWDATA);
            end else begin
                e = sq.pop_front();
                chk("strobe cycle", cyc(), e.c);
                chk("CAPWADDR", CAPWADDR, e.addr);
                chk("CAPWDATA", CAPWDATA, e.data);
            end
        end
        if (DONE === 1'b1) begin
            if (dq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected DONE at cycle %0d", cyc());
            end else begin
                dc = dq.pop_front();
                chk("DONE cycle", cyc(), dc);
                chk("BUSY at DONE", BUSY, 0);
            end
        end
    end

    task automatic begin_scn();
        RESET = 1'b1;
        START = 1'b0;
        ABORT = 1'b0;
        BOOTMODE = 1'b0;
        glitch_bit = -1;
        dbase = 134;
        repeat (2) @(negedge MCLK);
        RESET = 1'b0;
        @(negedge MCLK);
        base = ecount;
    endtask

    task automatic end_scn(input int c);
        at_cycle(c);
        chk("strobe queue drained", sq.size(), 0);
        chk("done queue drained", dq.size(), 0);
        sq.delete();
        dq.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " BUSY"}, BUSY, 0);
        chk({tag, " DONE"}, DONE, 0);
        chk({tag, " nBSEN"}, nBSEN, 1);
        chk({tag, " nREPEN"}, nREPEN, 1);
        chk({tag, " nBOOTEN"}, nBOOTEN, 1);
        chk({tag, " nCAPWCLKEN"}, nCAPWCLKEN, 1);
        chk({tag, " CAPWADDR"}, CAPWADDR, 0);
        chk({tag, " CAPWDATA"}, CAPWDATA, 0);
    endtask

    initial begin
        // Nominal read, BOOTMODE=0, glitch just before bit 5 strobe.
        begin_scn();
        chk_reset_vals("reset");
        glitch_bit = 5;
        push_access(100, 100000, 1);
        at_cycle(100); START = 1'b1;
        chk("nBSEN before start", nBSEN, 1);
        chk("BUSY before start", BUSY, 0);
        at_cycle(101); START = 1'b0;
        chk("nBSEN fall", nBSEN, 0);
        chk("BUSY rise", BUSY, 1);
        chk("nBOOTEN bootmode0", nBOOTEN, 1);
        at_cycle(110); chk("nREPEN before pulse", nREPEN, 1);
        at_cycle(111); chk("nREPEN first low", nREPEN, 0);
        at_cycle(113); chk("nREPEN last low", nREPEN, 0);
        at_cycle(114); chk("nREPEN rise T0", nREPEN, 1);
        at_cycle(150); chk("nBOOTEN mid bootmode0", nBOOTEN, 1);
        at_cycle(258); chk("BUSY last strobe", BUSY, 1);
        chk("nBSEN last strobe", nBSEN, 0);
        at_cycle(259); chk("BUSY release", BUSY, 0);
        chk("nBSEN release", nBSEN, 1);
        at_cycle(260); chk("BUSY idle after", BUSY, 0);
        end_scn(280);

        // BOOTMODE=1 latched at START, START re-pulsed mid-access.
        begin_scn();
        push_access(100, 100000, 1);
        at_cycle(100); START = 1'b1; BOOTMODE = 1'b1;
        chk("nBOOTEN before start", nBOOTEN, 1);
        at_cycle(101); START = 1'b0; BOOTMODE = 1'b0;
        chk("nBOOTEN low", nBOOTEN, 0);
        at_cycle(200); START = 1'b1;
        at_cycle(201); START = 1'b0;
        at_cycle(258); chk("nBOOTEN last strobe", nBOOTEN, 0);
        at_cycle(259); chk("nBOOTEN release", nBOOTEN, 1);
        end_scn(300);

        // ABORT at 150, then START+ABORT together in IDLE.
        begin_scn();
        push_access(100, 151, 0);
        at_cycle(100); START = 1'b1;
        at_cycle(101); START = 1'b0;
        at_cycle(150); ABORT = 1'b1;
        chk("nBSEN at abort", nBSEN, 0);
        at_cycle(151); ABORT = 1'b0;
        chk("nBSEN after abort", nBSEN, 1);
        chk("BUSY after abort", BUSY, 0);
        at_cycle(200); START = 1'b1; ABORT = 1'b1;
        at_cycle(201); START = 1'b0; ABORT = 1'b0;
        chk("start+abort idle nBSEN", nBSEN, 0);
        chk("start+abort idle BUSY", BUSY, 1);
        end_scn(230);

        // Asynchronous RESET mid-access, then a clean access.
        begin_scn();
        push_access(100, 180, 0);
        at_cycle(100); START = 1'b1; BOOTMODE = 1'b1;
        at_cycle(101); START = 1'b0; BOOTMODE = 1'b0;
        at_cycle(179); chk("nBOOTEN before reset", nBOOTEN, 0);
        at_cycle(180); RESET = 1'b1;
        #1;
        chk_reset_vals("async reset");
        at_cycle(182); RESET = 1'b0;
        dbase = 334;
        push_access(300, 100000, 1);
        at_cycle(300); START = 1'b1;
        chk("nBSEN idle after reset", nBSEN, 1);
        at_cycle(301); START = 1'b0;
        chk("nBSEN fall after reset", nBSEN, 0);
        end_scn(480);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc());
        $fatal(1, "watchdog");
    end

endmodule
